// File: rtl/prog_clk_divider_pkg.sv
// Shared constants and types for the programmable clock divider.
package clk_div_pkg;

  localparam int DIV_MIN = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } div_state_e;

  // Number of whole posedge cycles p_q stays high within one period.
  function automatic int unsigned half_cnt(input int unsigned n);
    return n >> 1;
  endfunction

endpackage

// File: rtl/prog_clk_divider_if.sv
// Control/status bundle of the programmable clock divider.
interface prog_clk_divider_if #(
  parameter int DIV_W = 8
);
  logic             en;
  logic             div_load;
  logic [DIV_W-1:0] div_val;
  logic             clk_out;
  logic             period_tick;
  logic             running;
  logic [DIV_W-1:0] div_active;
  logic             cfg_err;

  modport master (
    output en, div_load, div_val,
    input  clk_out, period_tick, running, div_active, cfg_err
  );

  modport slave (
    input  en, div_load, div_val,
    output clk_out, period_tick, running, div_active, cfg_err
  );
endinterface

// File: rtl/prog_clk_divider_clk_half_ext.sv
// Half-cycle extension for odd divisors: the only negedge logic in the divider.
module clk_half_ext (
  input  logic clk_in,
  input  logic rst,
  input  logic p_q,
  input  logic odd_q,
  output logic clk_out
);
  logic n_q;

  always_ff @(negedge clk_in or posedge rst) begin
    if (rst) n_q <= 1'b0;
    else     n_q <= p_q;
  end

  // n_q is low at every period boundary, so odd_q may switch there safely.
  assign clk_out = p_q | (odd_q & n_q);
endmodule

// File: rtl/prog_clk_divider.sv
// Runtime-programmable integer clock divider with 50% duty for odd and even N.
module prog_clk_divider
  import clk_div_pkg::*;
#(
  parameter int DIV_W   = 8,
  parameter int DEF_DIV = 5
) (
  input  logic               clk_in,
  input  logic               rst,
  prog_clk_divider_if.slave  bus
);
  localparam logic [DIV_W-1:0] DEF_V = DIV_W'(DEF_DIV);
  localparam logic [DIV_W-1:0] MIN_V = DIV_W'(DIV_MIN);
  localparam logic [DIV_W-1:0] ONE_V = DIV_W'(1);

  div_state_e       state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             odd_q, odd_d;
  logic             p_q, p_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;
  logic             run_q;
  logic             boundary;
  logic             load_ok;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + ONE_V;
    div_d      = div_q;
    odd_d      = odd_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;

    load_ok  = bus.div_load && (bus.div_val >= MIN_V);
    err_d    = bus.div_load && (bus.div_val < MIN_V);
    boundary = (state_q == IDLE) || (cnt_q == div_q - ONE_V);

    if (boundary) begin
      cnt_d = '0;
      if (pend_vld_q) begin
        div_d      = pend_q;
        odd_d      = pend_q[0];
        pend_vld_d = 1'b0;
      end
      state_d = bus.en ? RUN : IDLE;
    end

    // A load on a boundary edge lands after the swap, so it waits for the next one.
    if (load_ok) begin
      pend_d     = bus.div_val;
      pend_vld_d = 1'b1;
    end

    p_d    = (state_d == RUN) && (32'(cnt_d) < half_cnt(32'(div_d)));
    tick_d = (state_d == RUN) && (cnt_d == '0);
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_q      <= DEF_V;
      odd_q      <= DEF_V[0];
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      p_q        <= 1'b0;
      tick_q     <= 1'b0;
      err_q      <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      odd_q      <= odd_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      p_q        <= p_d;
      tick_q     <= tick_d;
      err_q      <= err_d;
      run_q      <= (state_d == RUN);
    end
  end

  clk_half_ext u_half (
    .clk_in  (clk_in),
    .rst     (rst),
    .p_q     (p_q),
    .odd_q   (odd_q),
    .clk_out (bus.clk_out)
  );

  assign bus.period_tick = tick_q;
  assign bus.running     = run_q;
  assign bus.div_active  = div_q;
  assign bus.cfg_err     = err_q;
endmodule

// File: tb/tb_prog_clk_divider.sv
// Directed + random bench for prog_clk_divider against a period-level reference model.
module tb_prog_clk_divider;
  localparam int DIV_W   = 8;
  localparam int DEF_DIV = 5;

  logic clk_in = 1'b0;
  logic rst    = 1'b0;

  prog_clk_divider_if #(.DIV_W(DIV_W)) bus ();

  prog_clk_divider #(.DIV_W(DIV_W), .DEF_DIV(DEF_DIV)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  // Reference model: edge index e, period start edge, next boundary edge, divisor, pending.
  int e       = 0;
  bit m_run   = 0;
  int m_div   = DEF_DIV;
  int m_pend  = 0;
  int m_start = -1;
  int m_nbnd  = 0;
  bit m_err   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h at edge %0d", tag, obs, exp, e);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_div = DEF_DIV; m_pend = 0; m_err = 0; m_start = -1; m_nbnd = 0;
  endtask

  task automatic model_edge();
    bit bnd;
    e++;
    bnd = !m_run || (e == m_nbnd);
    if (bnd) begin
      if (m_pend != 0) begin
        m_div  = m_pend;
        m_pend = 0;
      end
      if (bus.en) begin
        m_run = 1; m_start = e; m_nbnd = e + m_div;
      end else begin
        m_run = 0;
      end
    end
    m_err = 0;
    if (bus.div_load) begin
      if (int'(bus.div_val) >= 2) m_pend = int'(bus.div_val);
      else                        m_err  = 1;
    end
  endtask

  // Period of N cycles = 2N half-cycles, the first N of which are high.
  function automatic bit exp_clk(input int half);
    return m_run && ((2 * (e - m_start) + half) < m_div);
  endfunction

  task automatic cyc();
    @(posedge clk_in);
    model_edge();
    #1;
    chk("running",     bus.running,     m_run);
    chk("period_tick", bus.period_tick, m_run && (e == m_start));
    chk("div_active",  bus.div_active,  m_div);
    chk("cfg_err",     bus.cfg_err,     m_err);
    chk("clk_out_p",   bus.clk_out,     exp_clk(0));
    @(negedge clk_in);
    #1;
    chk("clk_out_n",   bus.clk_out,     exp_clk(1));
  endtask

  task automatic load(input int v);
    bus.div_load = 1'b1;
    bus.div_val  = DIV_W'(v);
    cyc();
    bus.div_load = 1'b0;
  endtask

  task automatic wait_start(input int lim);
    int n = 0;
    do begin
      cyc();
      n++;
    end while ((e != m_start) && (n < lim));
    chk("wait_start_timeout", 32'(e == m_start), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.en = 1'b0; bus.div_load = 1'b0; bus.div_val = '0;
    #1 rst = 1'b1;
    #2;
    chk("rst_clk_out",    bus.clk_out,     0);
    chk("rst_running",    bus.running,     0);
    chk("rst_tick",       bus.period_tick, 0);
    chk("rst_cfg_err",    bus.cfg_err,     0);
    chk("rst_div_active", bus.div_active,  DEF_DIV);
    bus.en = 1'b1;
    @(negedge clk_in); #1;
    rst = 1'b0;
    model_reset();

    // N=5 straight out of reset
    repeat (12) cyc();

    // Even, minimum and odd-minimum divisors, then the largest
    load(4);   wait_start(20); repeat (12) cyc();
    load(2);   repeat (10) cyc();
    load(3);   repeat (12) cyc();
    load(255); repeat (600) cyc();

    // Mid-period reload at count 2: current period unaffected
    load(5); wait_start(300); wait_start(20);
    cyc(); cyc();
    load(6); repeat (20) cyc();

    // Two loads in one period: last wins
    wait_start(20);
    load(7); cyc(); load(9); repeat (25) cyc();

    // Rejected divisors
    load(1); repeat (3) cyc();
    load(0); repeat (3) cyc();

    // Stop at count 1 of N=5, then restart
    load(5); wait_start(20); wait_start(20);
    cyc();
    bus.en = 1'b0;
    repeat (10) cyc();
    bus.en = 1'b1;
    repeat (12) cyc();

    // Randomised enable and loads
    repeat (400) begin
      bus.en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) begin
        bus.div_load = 1'b1;
        bus.div_val  = ($urandom_range(0, 3) == 0) ? DIV_W'($urandom_range(0, 255))
                                                    : DIV_W'($urandom_range(0, 12));
      end
      cyc();
      bus.div_load = 1'b0;
    end

    // Async reset in the middle of a high phase, with a divisor pending
    bus.en = 1'b1;
    load(9); wait_start(300); wait_start(20);
    load(7);
    chk("pre_rst_clk_high", bus.clk_out, 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_clk_out",    bus.clk_out,     0);
    chk("arst_div_active", bus.div_active,  DEF_DIV);
    chk("arst_running",    bus.running,     0);
    chk("arst_tick",       bus.period_tick, 0);
    @(negedge clk_in); #1;
    rst = 1'b0;
    model_reset();
    repeat (15) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
